// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and the MixColumns engine state type.
package aes_pkg;

  localparam int         AES_NB   = 4;
  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/mixcolumn_word.sv
// Combinational forward MixColumns of one 32-bit column; byte 0 of the column is the MSB.
module mixcolumn_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign b0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
  assign b1 = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
  assign b2 = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
  assign b3 = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);

  assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/mixcolumns_seq.sv
// Column-serial forward MixColumns engine with valid/ready on both sides.
//   state | meaning
//   IDLE  | empty, ready for a new state
//   BUSY  | mixing COLS_PER_CYCLE columns per cycle from src into res
//   DONE  | result presented; in_ready follows out_ready for back-to-back
module mixcolumns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] LAST_GROUP = 2'(AES_NB - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP   = 2'(COLS_PER_CYCLE);

  mc_state_e                   state_q, state_d;
  logic [1:0]                  col_cnt_q, col_cnt_d;
  // Element 3 holds column 0 so the packed vector matches the bus byte order.
  logic [AES_NB-1:0][31:0]     src_q, src_d;
  logic [AES_NB-1:0][31:0]     res_q, res_d;

  logic [1:0]  col_sel [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_sel[g] = col_cnt_q + 2'(g);
    assign col_in[g]  = src_q[2'd3 - col_sel[g]];

    mixcolumn_word u_mix (
      .col_i (col_in[g]),
      .col_o (col_out[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      src_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      src_q     <= src_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    src_d     = src_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          src_d     = in_data;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          res_d[2'd3 - col_sel[g]] = col_out[g];
        end
        // The 2-bit counter naturally wraps to 0 after the final group.
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == LAST_GROUP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            src_d     = in_data;
            col_cnt_d = 2'd0;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Bench for mixcolumns_seq: three instances (1, 2, 4 columns per cycle) against a GF(2^8) matrix model.
module tb_mixcolumns_seq;

  localparam int N = 3;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] in_data   [N];
  logic         in_valid  [N];
  logic         out_ready [N];
  wire  [127:0] out_data  [N];
  wire          in_ready  [N];
  wire          out_valid [N];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    mixcolumns_seq #(.COLS_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data[gi]),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .out_data  (out_data[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi])
    );
  end

  // Generic shift-and-add GF(2^8) multiply, polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Circulant matrix with first row {k0,k1,k2,k3} applied to every column.
  function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic [7:0] k0,
                                             input logic [7:0] k1, input logic [7:0] k2,
                                             input logic [7:0] k3);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    coef = '{k0, k1, k2, k3};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    return mat_apply(s, 8'd2, 8'd3, 8'd1, 8'd1);
  endfunction

  function automatic logic [127:0] inv_mix_model(input logic [127:0] s);
    return mat_apply(s, 8'd14, 8'd11, 8'd13, 8'd9);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  logic [127:0] exp_q [N][$];
  logic [127:0] orig_q [$];
  logic [127:0] prev_data [N];
  logic         prev_hold [N];

  // Scoreboard: expected results queued at input handshakes, checked at output handshakes.
  always @(negedge clk) begin
    logic [127:0] e;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        exp_q[i].delete();
        if (i == 2) orig_q.delete();
        prev_hold[i] = 1'b0;
      end else begin
        if (prev_hold[i]) begin
          chk("hold_valid", 128'(out_valid[i]), 128'd1);
          chk("hold_data", out_data[i], prev_data[i]);
        end
        if (out_valid[i]) chk("ready_follows", 128'(in_ready[i]), 128'(out_ready[i]));
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = exp_q[i].pop_front();
            chk("result", out_data[i], e);
            if (i == 2) chk("round_trip", inv_mix_model(out_data[i]), orig_q.pop_front());
          end
        end
        if (in_valid[i] && in_ready[i]) begin
          exp_q[i].push_back(mix_model(in_data[i]));
          if (i == 2) orig_q.push_back(in_data[i]);
        end
        prev_hold[i] = out_valid[i] && !out_ready[i];
        prev_data[i] = out_data[i];
      end
    end
  end

  task automatic wait_accept(input int i, output bit ok);
    int t;
    t = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!in_ready[i]) begin
      t++;
      if (t > 50) begin
        fail_now("accept_timeout");
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input int i, input logic [127:0] d, output int lat);
    bit ok;
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    wait_accept(i, ok);
    if (!ok) begin
      in_valid[i] = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    lat = 0;
    while (!out_valid[i]) begin
      if (lat > 20) begin
        fail_now("out_valid_timeout");
        return;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input int i);
    out_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int t;
    t = 0;
    while (exp_q[i].size() != 0) begin
      t++;
      if (t > 40) begin
        fail_now("drain_timeout");
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit ok;
    logic [127:0] tmp;

    for (int i = 0; i < N; i++) begin
      in_data[i]   = '0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_out_valid", 128'(out_valid[i]), 128'd0);
      chk("rst_in_ready", 128'(in_ready[i]), 128'd1);
      chk("rst_out_data", out_data[i], 128'd0);
    end
    reset = 1'b0;

    tmp = FIPS_IN;
    chk("pin_model_fips", mix_model(tmp), FIPS_OUT);
    tmp = V2_IN;
    chk("pin_model_v2", mix_model(tmp), V2_OUT);
    tmp = V2_OUT;
    chk("pin_model_inv", inv_mix_model(tmp), V2_IN);

    send(0, FIPS_IN, lat);
    chk("fips_latency", 128'(lat), 128'd4);
    chk("fips_data", out_data[0], FIPS_OUT);
    consume(0);

    for (int i = 0; i < N; i++) begin
      send(i, V2_IN, lat);
      chk("v2_latency", 128'(lat), 128'(4 >> i));
      chk("v2_data", out_data[i], V2_OUT);
      consume(i);
    end

    // Backpressure: a pending input must not be taken while the result is stalled.
    send(0, rand128(), lat);
    in_data[0]  = rand128();
    in_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
    end
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    chk("bp_after_valid", 128'(out_valid[0]), 128'd0);
    chk("bp_after_ready", 128'(in_ready[0]), 128'd1);
    chk("bp_single", 128'(exp_q[0].size()), 128'd0);

    // Back-to-back with out_ready held high.
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data[0] = rand128();
      wait_accept(0, ok);
      if (!ok) break;
      if (k > 0) chk("b2b_coincide", 128'(out_valid[0]), 128'd1);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    drain(0);
    out_ready[0] = 1'b0;

    // Asynchronous reset while BUSY with col_cnt = 2.
    @(posedge clk);
    #1;
    in_data[0]  = V2_IN;
    in_valid[0] = 1'b1;
    @(negedge clk);
    chk("rst_test_idle", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("midrst_out_data", out_data[0], 128'd0);
    chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(0, FIPS_IN, lat);
    chk("post_rst_latency", 128'(lat), 128'd4);
    chk("post_rst_data", out_data[0], FIPS_OUT);
    consume(0);

    // Round trip through the inverse transform on the 4-column instance.
    out_ready[2] = 1'b1;
    in_valid[2]  = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      in_data[2] = rand128();
      wait_accept(2, ok);
      if (!ok) break;
      @(posedge clk);
      #1;
    end
    in_valid[2] = 1'b0;
    drain(2);
    out_ready[2] = 1'b0;

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk("final_empty", 128'(exp_q[i].size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mixcolumns_seq.md
Name: mixcolumns_seq

Overview:
Forward AES MixColumns engine and the encrypt-side counterpart of the team's inverse MixColumns block. It accepts one 128-bit state per handshake and processes it column-serially, COLS_PER_CYCLE columns per cycle, trading area for latency. It returns the mixed state on a valid/ready output port. It sits in the encryption round datapath between ShiftRows and AddRoundKey.

Parameters:
COLS_PER_CYCLE, 1, number of 32-bit columns mixed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock; the only clock in the block
reset  input  1  asynchronous, active-high reset
in_data  input  128  state; column c = in_data[127-32c -: 32], byte r of the column = bits [127-32c-8r -: 8] (s0,c is the MSB)
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a state this cycle
out_data  output  128  mixed state, same byte layout as in_data
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, col_cnt=0, in_ready=1, out_valid=0, out_data=128'h0, internal buffers cleared.
- Transform per column (a0..a3), all arithmetic in GF(2^8) with polynomial 0x11B:
  - b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 8'h00), kept to 8 bits. 3x = xtime(x)^x.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into src_buf, set col_cnt=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle, mix columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 from src_buf and write them into the same column slots of res_buf. Then col_cnt += COLS_PER_CYCLE. After the group containing column 3 is written, go to DONE.
  - DONE: out_valid=1 and out_data=res_buf, held stable while out_ready=0.
    - in_ready = out_ready, so a new state can be accepted in the same cycle the output is consumed.
    - On out_ready with in_valid: latch the new state and go to BUSY (back-to-back operation).
    - On out_ready without in_valid: go to IDLE.
- Latency: out_valid rises exactly 4/COLS_PER_CYCLE clock edges after the accepting edge (4, 2 or 1). Throughput is one state per 4/COLS_PER_CYCLE+1 cycles when out_ready is held high.
- in_valid during BUSY is ignored; the source must hold it until in_ready. in_data is sampled only on the accepting edge.
- out_valid never drops without an out_ready handshake. out_data never changes while out_valid=1 and out_ready=0.
- col_cnt is 2 bits and is only meaningful in BUSY. It wraps to 0 on the transition to DONE.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. No partial result is ever presented.
- No combinational path from in_valid or in_data to out_data or out_valid. in_ready depends combinationally on out_ready only in DONE.

Decomposition:
- Package aes_pkg holds:
  - constants: AES_NB=4, AES_POLY=8'h1b
  - functions: xtime and gf_mul2/gf_mul3
  - the state enum (IDLE, BUSY, DONE)
- Sub-module mixcolumn_word: purely combinational, 32-bit column in, 32-bit mixed column out. Instantiate it COLS_PER_CYCLE times.
- The top level holds the FSM, col_cnt, src_buf, res_buf and the column select/write muxes.

Test Plan:
- FIPS-197 vector, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_c6c6c6c6 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising 4 edges after accept.
- Vector d4d4d4d5_2d26314c_00000000_ffffffff -> d5d5d7d6_4d7ebdf8_00000000_ffffffff, repeated for COLS_PER_CYCLE=1, 2 and 4 -> identical data, with latency 4, 2 and 1 respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, and a second in_valid is not accepted; raise out_ready -> one handshake only.
- Back-to-back: in_valid and out_ready held high with 8 random states -> each accept coincides with an output handshake; the result sequence matches the reference model in order.
- Reset mid-BUSY, asserted asynchronously between edges at col_cnt=2 -> out_valid=0, out_data=0 and in_ready=1 immediately; the next accepted state produces the correct result.
- Round trip: 1000 random states through this block and then the inverse MixColumns transform -> output equals the original input.
